// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage sequencer between EX/MEM and MEM/WB.
// It issues load/store accesses over a req/ack handshake and stalls the
// upstream pipeline while an access is outstanding. It also drives the
// MEM/WB inputs and aborts accesses that exceed a wait-cycle budget.
module mem_stage_ctrl #(
  parameter int unsigned MAX_WAIT   = 15,
  parameter logic [31:0] BUBBLE_SEL = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic        ex_lw,
  input  logic        ex_sw,
  input  logic [31:0] ex_daddr,
  input  logic [31:0] ex_store,
  input  logic [31:0] ex_dselect,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [31:0] wb_daddr,
  output logic [31:0] wb_data,
  output logic [31:0] wb_dselect,
  output logic        wb_sw,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] lat_dsel;

  // Sequencer: mem_addr/mem_wdata/mem_we double as the latched address,
  // store data and op type, since they must stay stable during the access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      lat_dsel   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      stall      <= 1'b0;
      wb_daddr   <= '0;
      wb_data    <= '0;
      wb_dselect <= BUBBLE_SEL;
      wb_sw      <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Bubble unless a branch below produces a real result.
      wb_daddr   <= '0;
      wb_data    <= '0;
      wb_dselect <= BUBBLE_SEL;
      wb_sw      <= 1'b0;
      // Clear first so any error set below takes priority.
      if (err_clr) begin
        err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (ex_lw && ex_sw) begin
              err <= 1'b1;
            end else if (ex_lw || ex_sw) begin
              mem_addr  <= ex_daddr;
              mem_wdata <= ex_store;
              mem_we    <= ex_sw;
              lat_dsel  <= ex_dselect;
              mem_req   <= 1'b1;
              stall     <= 1'b1;
              wait_cnt  <= '0;
              state     <= ACCESS;
            end else begin
              wb_daddr   <= ex_daddr;
              wb_data    <= ex_daddr;
              wb_dselect <= ex_dselect;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            stall    <= 1'b0;
            state    <= IDLE;
            wb_daddr <= mem_addr;
            if (mem_we) begin
              wb_data <= mem_wdata;
              wb_sw   <= 1'b1;
            end else begin
              wb_data    <= mem_rdata;
              wb_dselect <= lat_dsel;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            mem_req <= 1'b0;
            stall   <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a
// transaction-level reference model.
module tb_mem_stage_ctrl;

  localparam int unsigned TB_MAX_WAIT = 4;
  localparam logic [31:0] TB_BUBBLE   = 32'h0000_0001;

  logic        clk;
  logic        reset_n;
  logic        ex_valid, ex_lw, ex_sw;
  logic [31:0] ex_daddr, ex_store, ex_dselect;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic [31:0] wb_daddr, wb_data, wb_dselect;
  logic        wb_sw, err, err_clr;

  mem_stage_ctrl #(.MAX_WAIT(TB_MAX_WAIT), .BUBBLE_SEL(TB_BUBBLE)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_lw(ex_lw), .ex_sw(ex_sw),
    .ex_daddr(ex_daddr), .ex_store(ex_store), .ex_dselect(ex_dselect),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .wb_daddr(wb_daddr), .wb_data(wb_data),
    .wb_dselect(wb_dselect), .wb_sw(wb_sw), .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction record plus expected outputs.
  logic        m_busy;
  int          m_waited;
  logic [31:0] m_dsel;
  logic        e_req, e_we, e_stall, e_wb_sw, e_err;
  logic [31:0] e_addr, e_wdata, e_wb_daddr, e_wb_data, e_wb_dsel;

  int req_cycles;
  int stall_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_waited = 0; m_dsel = '0;
    e_req = 1'b0; e_we = 1'b0; e_stall = 1'b0; e_wb_sw = 1'b0; e_err = 1'b0;
    e_addr = '0; e_wdata = '0; e_wb_daddr = '0; e_wb_data = '0;
    e_wb_dsel = TB_BUBBLE;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic set_err;
    set_err    = 1'b0;
    e_wb_daddr = '0; e_wb_data = '0; e_wb_dsel = TB_BUBBLE; e_wb_sw = 1'b0;
    if (!m_busy) begin
      if (ex_valid && ex_lw && ex_sw) begin
        set_err = 1'b1;
      end else if (ex_valid && (ex_lw || ex_sw)) begin
        m_busy   = 1'b1;
        m_waited = 0;
        m_dsel   = ex_dselect;
        e_req    = 1'b1;
        e_stall  = 1'b1;
        e_we     = ex_sw;
        e_addr   = ex_daddr;
        e_wdata  = ex_store;
      end else if (ex_valid) begin
        e_wb_daddr = ex_daddr;
        e_wb_data  = ex_daddr;
        e_wb_dsel  = ex_dselect;
      end
    end else begin
      m_waited++;
      if (mem_ack) begin
        m_busy = 1'b0; e_req = 1'b0; e_stall = 1'b0;
        e_wb_daddr = e_addr;
        if (e_we) begin
          e_wb_data = e_wdata;
          e_wb_sw   = 1'b1;
        end else begin
          e_wb_data = mem_rdata;
          e_wb_dsel = m_dsel;
        end
      end else if (m_waited == int'(TB_MAX_WAIT)) begin
        m_busy = 1'b0; e_req = 1'b0; e_stall = 1'b0;
        set_err = 1'b1;
      end
    end
    if (set_err) e_err = 1'b1;
    else if (err_clr) e_err = 1'b0;
  endtask

  task automatic compare();
    chk("mem_req", {31'b0, mem_req}, {31'b0, e_req});
    chk("stall", {31'b0, stall}, {31'b0, e_stall});
    chk("wb_daddr", wb_daddr, e_wb_daddr);
    chk("wb_data", wb_data, e_wb_data);
    chk("wb_dselect", wb_dselect, e_wb_dsel);
    chk("wb_sw", {31'b0, wb_sw}, {31'b0, e_wb_sw});
    chk("err", {31'b0, err}, {31'b0, e_err});
    if (e_req) begin
      chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
    if (mem_req) req_cycles++;
    if (stall) stall_cycles++;
  endtask

  task automatic set_ex(input logic v, input logic lw, input logic sw,
                        input logic [31:0] a, input logic [31:0] s, input logic [31:0] d);
    ex_valid = v; ex_lw = lw; ex_sw = sw;
    ex_daddr = a; ex_store = s; ex_dselect = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset_n = 1'b0; err_clr = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    set_ex(1'b0, 1'b0, 1'b0, '0, '0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    compare();
    chk("reset_wb_dselect", wb_dselect, 32'h0000_0001);
    chk("reset_mem_req", {31'b0, mem_req}, 32'h0);
    reset_n = 1'b1;

    // ALU pass-through
    set_ex(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 32'h4);
    tick();
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_wb_dselect", wb_dselect, 32'h4);
    chk("alu_wb_sw", {31'b0, wb_sw}, 32'h0);
    chk("alu_stall", {31'b0, stall}, 32'h0);

    // Load acknowledged on the third ACCESS cycle
    req_cycles = 0; stall_cycles = 0;
    set_ex(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 32'h8);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk("ld_wb_bubble", wb_dselect, 32'h1);
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    chk("ld_req_cycles", req_cycles, 32'd3);
    chk("ld_stall_cycles", stall_cycles, 32'd3);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    chk("ld_wb_dselect", wb_dselect, 32'h8);

    // Store with immediate ack, then the held ALU op
    set_ex(1'b1, 1'b0, 1'b1, 32'h80, 32'h55, 32'h10);
    tick();
    chk("st_mem_we", {31'b0, mem_we}, 32'h1);
    chk("st_mem_wdata", mem_wdata, 32'h55);
    set_ex(1'b1, 1'b0, 1'b0, 32'h99, 32'h0, 32'h20);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("st_wb_sw", {31'b0, wb_sw}, 32'h1);
    chk("st_wb_dselect", wb_dselect, 32'h1);
    chk("st_wb_data", wb_data, 32'h55);
    chk("st_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("held_alu_wb_data", wb_data, 32'h99);
    chk("held_alu_wb_dselect", wb_dselect, 32'h20);

    // Timeout with no ack
    req_cycles = 0;
    set_ex(1'b1, 1'b1, 1'b0, 32'hC0, 32'h0, 32'h40);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (4) tick();
    chk("to_req_cycles", req_cycles, 32'd4);
    chk("to_err", {31'b0, err}, 32'h1);
    chk("to_wb_dselect", wb_dselect, 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_clr", {31'b0, err}, 32'h0);

    // Ack on the timeout cycle
    set_ex(1'b1, 1'b1, 1'b0, 32'hD0, 32'h0, 32'h100);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) tick();
    chk("ackto_req_held", {31'b0, mem_req}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
    tick();
    mem_ack = 1'b0;
    chk("ackto_req", {31'b0, mem_req}, 32'h0);
    chk("ackto_err", {31'b0, err}, 32'h0);
    chk("ackto_wb_data", wb_data, 32'hCAFE0001);

    // Illegal lw + sw
    set_ex(1'b1, 1'b1, 1'b1, 32'hE0, 32'h1, 32'h2);
    tick();
    chk("ill_err", {31'b0, err}, 32'h1);
    chk("ill_req", {31'b0, mem_req}, 32'h0);
    set_ex(1'b0, 1'b0, 1'b0, '0, '0, '0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Asynchronous reset in the middle of an access
    set_ex(1'b1, 1'b1, 1'b0, 32'hF0, 32'h0, 32'h200);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mid_stall", {31'b0, stall}, 32'h0);
    chk("rst_mid_wb_dselect", wb_dselect, 32'h1);
    compare();
    #2;
    reset_n = 1'b1;

    // Randomized traffic; EX/MEM holds while the model says the stage stalls
    for (int i = 0; i < 3000; i++) begin
      if (!m_busy) begin
        int unsigned k;
        k = $urandom_range(0, 99);
        set_ex($urandom_range(0, 3) != 0, k >= 50 && k < 72, k >= 72 && k < 94,
               $urandom, $urandom, 32'h1 << $urandom_range(0, 31));
        if (k >= 94) begin
          ex_lw = 1'b1; ex_sw = 1'b1;
        end
      end
      mem_ack   = ($urandom_range(0, 9) < 3);
      mem_rdata = $urandom;
      err_clr   = ($urandom_range(0, 9) == 0);
      tick();
    end
    mem_ack = 1'b0; err_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage sequencer sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It issues load/store accesses to a data memory that has variable latency and a request/acknowledge handshake, and it stalls the upstream pipeline while an access is outstanding. It also drives the MEM/WB register inputs: pass-through values for ALU instructions, memory data for loads, and bubbles while stalled. A wait-cycle watchdog aborts accesses the memory never acknowledges.

## Interface
Parameters:
- MAX_WAIT, 15: maximum ACCESS cycles before abort (1..255).
- BUBBLE_SEL, 32'h0000_0001: Dselect value for a bubble (one-hot R0; R0 writes are discarded).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- ex_valid  in  1  EX/MEM holds a valid instruction.
- ex_lw  in  1  instruction is a load word.
- ex_sw  in  1  instruction is a store word.
- ex_daddr  in  32  ALU result / effective address.
- ex_store  in  32  store data.
- ex_dselect  in  32  one-hot destination register select.
- mem_req  out  1  access request, held until ack or abort.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req = 1.
- mem_addr  out  32  access address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, sampled when mem_ack = 1.
- mem_ack  in  1  access complete, single-cycle pulse.
- stall  out  1  registered; while 1, upstream stages and EX/MEM hold.
- wb_daddr  out  32  to MEM/WB daddrbus input.
- wb_data  out  32  to MEM/WB databus input.
- wb_dselect  out  32  to MEM/WB Dselect input.
- wb_sw  out  1  to MEM/WB SW input.
- err  out  1  sticky: timeout or illegal op.
- err_clr  in  1  synchronous clear of err.

## Operation
- States: IDLE, ACCESS. All outputs are registered.
- Reset values:
  - State is IDLE.
  - mem_req, mem_we, stall, wb_sw and err are 0.
  - mem_addr, mem_wdata, wb_daddr and wb_data are 0.
  - wb_dselect is BUBBLE_SEL.
  - The wait counter is 0.
- IDLE, ex_valid = 0: at the next edge, wb outputs take bubble values (wb_dselect = BUBBLE_SEL, wb_sw = 0, wb_data = 0, wb_daddr = 0).
- IDLE, ex_valid = 1, neither lw nor sw: pass-through at the next edge.
  - wb_daddr = ex_daddr, wb_data = ex_daddr, wb_dselect = ex_dselect, wb_sw = 0.
- IDLE, ex_valid = 1, exactly one of lw/sw (accept edge):
  - Latch ex_daddr, ex_store and ex_dselect internally.
  - Drive mem_addr = ex_daddr, mem_wdata = ex_store, mem_we = ex_sw, mem_req = 1, stall = 1.
  - Clear the wait counter, output a bubble to wb, and go to ACCESS.
- IDLE, ex_lw = ex_sw = 1: set err, output a bubble, and stay in IDLE. No access is issued.
- ACCESS, mem_ack = 0:
  - Increment the wait counter and keep outputting bubbles.
  - When the counter reaches MAX_WAIT − 1, abort: mem_req = 0, stall = 0, set err, output a bubble, go to IDLE.
- ACCESS, mem_ack = 1 (completion edge): mem_req = 0, stall = 0, go to IDLE.
  - Load: wb_daddr = latched addr, wb_data = mem_rdata, wb_dselect = latched dselect, wb_sw = 0.
  - Store: wb_daddr = latched addr, wb_data = latched store data, wb_dselect = BUBBLE_SEL, wb_sw = 1.
- mem_ack is ignored in IDLE.
- Ack on the timeout cycle: ack wins and the access completes normally with no err.
- err_clr and a same-cycle error event: set wins.
- reset_n low mid-access: mem_req and stall drop immediately (asynchronously), the latched op is discarded, and no wb write occurs.

## Timing
- ALU op: EX/MEM to wb outputs in 1 cycle.
- Memory op accepted at edge T0:
  - mem_req is high from T0 until the ack edge Tk.
  - The wb result appears at Tk.
  - stall is high for exactly k cycles, (T0, Tk].
- EX/MEM is not stalled at T0, so the following instruction loads into EX/MEM at T0 and is held while stall = 1.
- That held instruction is evaluated in the IDLE cycle after Tk. Back-to-back memory ops therefore accept at Tk+1, giving a minimum issue interval of 2 cycles when the ack comes in the first ACCESS cycle.
- An aborted access holds mem_req for exactly MAX_WAIT cycles.
- mem_addr, mem_wdata and mem_we are stable for the whole duration of mem_req = 1.

## Test plan
- Reset then ALU op: ex_daddr = 32'h1234, ex_dselect = 32'h4 → next edge wb_data = 32'h1234, wb_dselect = 32'h4, wb_sw = 0, stall = 0.
- Load, ack on the 3rd ACCESS cycle:
  - Stimulus: addr 32'h40, mem_rdata = 32'hDEADBEEF.
  - Required: mem_req high 3 cycles, stall high 3 cycles, bubbles until completion.
  - Then wb_data = 32'hDEADBEEF with the latched dselect.
- Store with immediate ack: addr 32'h80, data 32'h55 → mem_we = 1, mem_wdata = 32'h55; completion gives wb_sw = 1, wb_dselect = BUBBLE_SEL. Then a held ALU op is accepted the following cycle.
- Timeout: MAX_WAIT = 4, no ack → mem_req high 4 cycles, then err = 1 and a bubble. err_clr then gives err = 0.
- Ack on the timeout cycle → normal completion, err stays 0.
- Illegal lw + sw → err = 1, mem_req stays 0. Separately, assert reset_n low during ACCESS → mem_req and stall go 0 before the next edge and wb_dselect = BUBBLE_SEL.
